// File: rtl/rv32_mem_arbiter.sv
// Two-master (CPU byte/half/word, DMA word) arbiter in front of a single-port synchronous SRAM.
// Priority toggles to the CPU after DMA_BURST_MAX starving DMA grants; responses arrive one cycle after grant.
module rv32_mem_arbiter #(
  parameter int XLEN          = 32,
  parameter int DMA_BURST_MAX = 8,
  parameter int MEM_AW        = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [XLEN-1:0]   cpu_addr,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_size,
  input  logic [XLEN-1:0]   cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_err,
  output logic [XLEN-1:0]   cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [XLEN-1:0]   dma_addr,
  input  logic [XLEN-1:0]   dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic              dma_err,
  output logic [XLEN-1:0]   dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              dbg_state,
  output logic [7:0]        dbg_burst_cnt
);

  // Handshake: a request is consumed in the cycle its *_gnt is high (no ready
  // back-pressure beyond the grant). Exactly one cycle later the master sees
  // either *_rvalid (legal read), *_err (illegal access) or nothing (legal write).

  typedef enum logic {DMA_PRI = 1'b0, CPU_PRI = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_burst_cnt;
  logic        r_cpu_rvalid;
  logic        r_cpu_err;
  logic        r_dma_rvalid;
  logic        r_dma_err;

  logic        w_cpu_gnt;
  logic        w_dma_gnt;
  logic        w_cpu_hi_bad;
  logic        w_dma_hi_bad;
  logic        w_cpu_legal;
  logic        w_dma_legal;
  logic [3:0]  w_cpu_be;
  logic [31:0] w_cpu_wdata32;
  logic        w_burst_last;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  assign w_cpu_hi_bad = (cpu_addr >> (MEM_AW + 2)) != '0;
  assign w_dma_hi_bad = (dma_addr >> (MEM_AW + 2)) != '0;

  always_comb begin
    w_cpu_legal   = 1'b0;
    w_cpu_be      = 4'b1111;
    w_cpu_wdata32 = cpu_wdata[31:0];
    case (cpu_size)
      3'd0: begin
        w_cpu_legal   = !w_cpu_hi_bad;
        w_cpu_be      = 4'b0001 << cpu_addr[1:0];
        w_cpu_wdata32 = {4{cpu_wdata[7:0]}};
      end
      3'd1: begin
        w_cpu_legal   = !w_cpu_hi_bad && !cpu_addr[0];
        w_cpu_be      = cpu_addr[1] ? 4'b1100 : 4'b0011;
        w_cpu_wdata32 = {2{cpu_wdata[15:0]}};
      end
      3'd2: begin
        w_cpu_legal   = !w_cpu_hi_bad && (cpu_addr[1:0] == 2'b00);
        w_cpu_be      = 4'b1111;
        w_cpu_wdata32 = cpu_wdata[31:0];
      end
      default: begin
        w_cpu_legal   = 1'b0;
        w_cpu_be      = 4'b1111;
        w_cpu_wdata32 = cpu_wdata[31:0];
      end
    endcase
  end

  assign w_dma_legal = !w_dma_hi_bad && (dma_addr[1:0] == 2'b00);

  // ---------------------------------------------------------------------------
  // Priority FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DMA_PRI;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Last starving DMA grant of a burst hands priority to the CPU
  assign w_burst_last = w_dma_gnt && cpu_req &&
                        (r_burst_cnt == 8'(DMA_BURST_MAX - 1));

  // Priority FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DMA_PRI: begin
        if (w_burst_last) begin
          w_state_nxt = CPU_PRI;
        end
      end
      CPU_PRI: begin
        if (w_cpu_gnt || !cpu_req) begin
          w_state_nxt = DMA_PRI;
        end
      end
      default: w_state_nxt = DMA_PRI;
    endcase
  end

  // Priority FSM: outputs (grants). Grants are held low throughout reset.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    if (rst_n) begin
      case (r_state)
        CPU_PRI: begin
          w_cpu_gnt = cpu_req;
          w_dma_gnt = dma_req && !cpu_req;
        end
        default: begin
          w_dma_gnt = dma_req;
          w_cpu_gnt = cpu_req && !dma_req;
        end
      endcase
    end
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign dma_gnt   = w_dma_gnt;
  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Starvation counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= 8'd0;
    end else if (!cpu_req || w_cpu_gnt) begin
      r_burst_cnt <= 8'd0;
    end else if (w_dma_gnt) begin
      r_burst_cnt <= r_burst_cnt + 8'd1;
    end
  end

  assign dbg_burst_cnt = r_burst_cnt;

  // ---------------------------------------------------------------------------
  // SRAM request mux
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_en    = w_cpu_legal;
      mem_we    = cpu_we && w_cpu_legal;
      mem_be    = w_cpu_legal ? w_cpu_be : 4'b0000;
      mem_addr  = cpu_addr[MEM_AW+1:2];
      mem_wdata = XLEN'(w_cpu_wdata32);
    end else if (w_dma_gnt) begin
      mem_en    = w_dma_legal;
      mem_we    = dma_we && w_dma_legal;
      mem_be    = w_dma_legal ? 4'b1111 : 4'b0000;
      mem_addr  = dma_addr[MEM_AW+1:2];
      mem_wdata = dma_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response tracking: one cycle after grant
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rvalid <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_dma_err    <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt && w_cpu_legal && !cpu_we;
      r_cpu_err    <= w_cpu_gnt && !w_cpu_legal;
      r_dma_rvalid <= w_dma_gnt && w_dma_legal && !dma_we;
      r_dma_err    <= w_dma_gnt && !w_dma_legal;
    end
  end

  // Read data is the raw SRAM word; byte-lane extraction is left to the core
  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_err    = r_cpu_err;
  assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : '0;
  assign dma_rvalid = r_dma_rvalid;
  assign dma_err    = r_dma_err;
  assign dma_rdata  = r_dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter: DMA streaming, burst fairness, CPU lanes,
// illegal accesses and reset mid-access, against a behavioural synchronous SRAM.
module tb_rv32_mem_arbiter;

  localparam int XLEN          = 32;
  localparam int DMA_BURST_MAX = 8;
  localparam int MEM_AW        = 14;

  logic              clk;
  logic              rst_n;
  logic              cpu_req;
  logic [XLEN-1:0]   cpu_addr;
  logic              cpu_we;
  logic [2:0]        cpu_size;
  logic [XLEN-1:0]   cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic              cpu_err;
  logic [XLEN-1:0]   cpu_rdata;
  logic              dma_req;
  logic              dma_we;
  logic [XLEN-1:0]   dma_addr;
  logic [XLEN-1:0]   dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic              dma_err;
  logic [XLEN-1:0]   dma_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;
  logic              dbg_state;
  logic [7:0]        dbg_burst_cnt;

  int                n_checks;
  int                n_fail;
  logic [31:0]       exp_q[$];
  logic [31:0]       exp_v;
  logic [19:0]       pat;

  rv32_mem_arbiter #(
    .XLEN(XLEN), .DMA_BURST_MAX(DMA_BURST_MAX), .MEM_AW(MEM_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_err(dma_err), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_burst_cnt(dbg_burst_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous SRAM with byte enables
  logic [31:0] sram [0:(1<<MEM_AW)-1];
  initial begin
    for (int i = 0; i < (1 << MEM_AW); i++) sram[i] = 32'h0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_idle();
    cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_size = 3'd2; cpu_wdata = '0;
    dma_req = 1'b0; dma_addr = '0; dma_we = 1'b0; dma_wdata = '0;
  endtask

  task automatic set_cpu(input logic [31:0] a, input logic we, input logic [2:0] sz,
                         input logic [31:0] wd);
    cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_size = sz; cpu_wdata = wd;
  endtask

  task automatic set_dma(input logic [31:0] a, input logic we, input logic [31:0] wd);
    dma_req = 1'b1; dma_addr = a; dma_we = we; dma_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_idle();
    set_cpu(32'h200, 1'b0, 3'd2, 32'h0);
    set_dma(32'h100, 1'b0, 32'h0);

    // Reset: requests present but nothing may be granted
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_dma_gnt", dma_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_state", dbg_state, 0);
    check("rst_burst", dbg_burst_cnt, 0);
    check("rst_rvalid", {cpu_rvalid, dma_rvalid, cpu_err, dma_err}, 0);
    next_cycle();
    set_idle();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_mem_en", mem_en, 0);
    next_cycle();

    // DMA word writes 0x100..0x10C
    for (int i = 0; i < 4; i++) begin
      set_dma(32'h100 + 4*i, 1'b1, 32'hD00D_0000 + i);
      @(negedge clk);
      check("dmaw_gnt", dma_gnt, 1);
      check("dmaw_en", {mem_en, mem_we}, 2'b11);
      check("dmaw_be", mem_be, 4'hF);
      check("dmaw_addr", mem_addr, 32'h40 + i);
      check("dmaw_wdata", mem_wdata, 32'hD00D_0000 + i);
      next_cycle();
    end
    // DMA reads back-to-back, expected data tracked in a queue
    for (int i = 0; i < 5; i++) begin
      set_idle();
      if (i < 4) set_dma(32'h100 + 4*i, 1'b0, 32'h0);
      @(negedge clk);
      if (i < 4) check("dmar_gnt", dma_gnt, 1);
      if (i == 0) begin
        check("dmaw_no_rvalid", dma_rvalid, 0);
      end else begin
        check("dmar_rvalid", dma_rvalid, 1);
        exp_v = exp_q.pop_front();
        check("dmar_rdata", dma_rdata, exp_v);
      end
      if (i < 4) exp_q.push_back(32'hD00D_0000 + i);
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    check("dma_idle_rvalid", dma_rvalid, 0);
    check("dma_idle_rdata", dma_rdata, 0);
    next_cycle();

    // Both masters held 20 cycles: 8 DMA, 1 CPU, 8 DMA, 1 CPU, 2 DMA (bit i = DMA wins cycle i)
    pat = 20'b11_0_11111111_0_11111111;
    set_cpu(32'h200, 1'b0, 3'd2, 32'h0);
    set_dma(32'h104, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("burst_dma_gnt", dma_gnt, pat[i]);
      check("burst_cpu_gnt", cpu_gnt, !pat[i]);
      check("burst_state", dbg_state, (i == 8 || i == 17) ? 1 : 0);
      if (i > 0) begin
        check("burst_dma_rvalid", dma_rvalid, pat[i-1]);
        check("burst_cpu_rvalid", cpu_rvalid, !pat[i-1]);
      end
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    check("burst_tail_rvalid", {dma_rvalid, cpu_rvalid}, 2'b10);
    check("burst_tail_rdata", dma_rdata, 32'hD00D_0001);
    next_cycle();

    // CPU sb 0xAB @0x203, sh 0x5678 @0x200, lw @0x200
    set_cpu(32'h203, 1'b1, 3'd0, 32'h0000_00AB);
    @(negedge clk);
    check("sb_gnt", cpu_gnt, 1);
    check("sb_en", {mem_en, mem_we}, 2'b11);
    check("sb_be", mem_be, 4'b1000);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_addr", mem_addr, 32'h80);
    next_cycle();
    set_cpu(32'h200, 1'b1, 3'd1, 32'h0000_5678);
    @(negedge clk);
    check("sh_be", mem_be, 4'b0011);
    check("sh_wdata", mem_wdata, 32'h5678_5678);
    check("sb_no_resp", {cpu_rvalid, cpu_err}, 0);
    next_cycle();
    set_cpu(32'h200, 1'b0, 3'd2, 32'h0);
    @(negedge clk);
    check("lw_be", mem_be, 4'hF);
    check("lw_we", mem_we, 0);
    next_cycle();
    set_idle();
    @(negedge clk);
    check("lw_rvalid", {cpu_rvalid, cpu_err}, 2'b10);
    check("lw_rdata", cpu_rdata, 32'hAB00_5678);
    check("lw_byte3", cpu_rdata[31:24], 32'hAB);
    check("idle_mem_en2", mem_en, 0);
    next_cycle();

    // Illegal accesses: misaligned half, out-of-range word, bad size, misaligned DMA
    set_cpu(32'h201, 1'b0, 3'd1, 32'h0);
    @(negedge clk);
    check("lh_odd_gnt", cpu_gnt, 1);
    check("lh_odd_en", mem_en, 0);
    next_cycle();
    set_cpu(32'h1_0000, 1'b0, 3'd2, 32'h0);
    @(negedge clk);
    check("lw_oor_gnt", cpu_gnt, 1);
    check("lw_oor_en", mem_en, 0);
    check("lh_odd_err", {cpu_err, cpu_rvalid}, 2'b10);
    check("lh_odd_rdata", cpu_rdata, 0);
    next_cycle();
    set_cpu(32'h204, 1'b0, 3'd3, 32'h0);
    @(negedge clk);
    check("sz3_en", {cpu_gnt, mem_en}, 2'b10);
    check("lw_oor_err", {cpu_err, cpu_rvalid}, 2'b10);
    check("lw_oor_rdata", cpu_rdata, 0);
    next_cycle();
    set_idle();
    set_dma(32'h102, 1'b0, 32'h0);
    @(negedge clk);
    check("dma_mis_en", {dma_gnt, mem_en}, 2'b10);
    check("sz3_err", cpu_err, 1);
    next_cycle();
    set_idle();
    @(negedge clk);
    check("dma_mis_err", {dma_err, dma_rvalid, cpu_err}, 3'b100);
    check("dma_mis_rdata", dma_rdata, 0);
    next_cycle();

    // Reset one cycle after a DMA read grant, with burst count built up
    set_cpu(32'h200, 1'b0, 3'd2, 32'h0);
    set_dma(32'h100, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pre_rst_gnt", {dma_gnt, cpu_gnt}, 2'b10);
      if (i == 2) check("pre_rst_burst", dbg_burst_cnt, 2);
      next_cycle();
    end
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    check("mid_rst_rvalid", dma_rvalid, 0);
    check("mid_rst_burst", dbg_burst_cnt, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rvalid", {dma_rvalid, dma_err, cpu_rvalid, cpu_err}, 0);
    check("post_rst_state", dbg_state, 0);
    check("post_rst_burst", dbg_burst_cnt, 0);
    next_cycle();
    @(negedge clk);
    check("post_rst_rvalid2", dma_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
